// File: rtl/shell_pkg.sv
// -----------------------------------------------------------------------------
// shell_pkg
// Shared constants and types for the shell hit judge and its neighbours.
//   GAME_PLAY / GAME_RESTART : game_state codes driven by the game FSM
//   N_SHELL / POS_W          : shells per tank and coordinate width
//   UP/DOWN/LEFT/RIGHT       : shell direction codes used by the shell block
//   scan_state_e             : judge FSM states (ST_CHECK is only reached
//                              when SHELL_WALL_MAP_EN is defined)
// -----------------------------------------------------------------------------
package shell_pkg;

  localparam logic [1:0] GAME_PLAY    = 2'b01;
  localparam logic [1:0] GAME_RESTART = 2'b10;

  localparam int N_SHELL = 5;
  localparam int POS_W   = 6;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;

  // ST_SCAN doubles as the address phase of the wall-map build.
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_RESTART = 2'd3
  } scan_state_e;

endpackage

// File: rtl/shell_hit_judge_if.sv
// -----------------------------------------------------------------------------
// shell_hit_judge_if
// Bundles the signals between the judge, the shell block and the game FSM.
//   slave  : the judge (reads positions/state, drives vanish/hit/life count)
//   master : the environment (shell block, game FSM, wall ROM)
// Optional macro SHELL_WALL_MAP_EN adds wall_rd_addr / wall_rd_data.
//
// Shell hand-back protocol: the judge pulses vanish[i] for one cycle; the
// shell block answers by raising valid_shell[i] (idle) some cycles later.
// The judge will not pulse vanish[i] again until it has seen valid_shell[i]=1.
// -----------------------------------------------------------------------------
interface shell_hit_judge_if;
  import shell_pkg::*;

  logic [1:0]               game_state;
  logic [N_SHELL*POS_W-1:0] shell_x_pos;
  logic [N_SHELL*POS_W-1:0] shell_y_pos;
  logic [N_SHELL-1:0]       valid_shell;
  logic [POS_W-1:0]         enemy_x_pos;
  logic [POS_W-1:0]         enemy_y_pos;
  logic [N_SHELL-1:0]       vanish;
  logic                     hit;
  logic [1:0]               hit_count;
  logic                     dead;
  scan_state_e              dbg_state;
`ifdef SHELL_WALL_MAP_EN
  logic [2*POS_W-1:0]       wall_rd_addr;
  logic                     wall_rd_data;
`endif

  modport slave (
    input  game_state, shell_x_pos, shell_y_pos, valid_shell,
    input  enemy_x_pos, enemy_y_pos,
`ifdef SHELL_WALL_MAP_EN
    input  wall_rd_data,
    output wall_rd_addr,
`endif
    output vanish, hit, hit_count, dead, dbg_state
  );

  modport master (
    output game_state, shell_x_pos, shell_y_pos, valid_shell,
    output enemy_x_pos, enemy_y_pos,
`ifdef SHELL_WALL_MAP_EN
    output wall_rd_data,
    input  wall_rd_addr,
`endif
    input  vanish, hit, hit_count, dead, dbg_state
  );

endinterface

// File: rtl/cell_in_box.sv
// -----------------------------------------------------------------------------
// cell_in_box
// Combinational test: is point (i_pt_x,i_pt_y) inside the square box whose
// top-left corner is (i_box_x,i_box_y) and whose side is i_size cells?
//   i_pt_x, i_pt_y   : point
//   i_box_x, i_box_y : box origin
//   i_size           : box side in cells (>= 1)
//   o_inside         : 1 when the point lies in the box
// The far edge is computed one bit wider so a box near 63 does not wrap.
// -----------------------------------------------------------------------------
module cell_in_box
  import shell_pkg::*;
(
  input  logic [POS_W-1:0] i_pt_x,
  input  logic [POS_W-1:0] i_pt_y,
  input  logic [POS_W-1:0] i_box_x,
  input  logic [POS_W-1:0] i_box_y,
  input  logic [POS_W-1:0] i_size,
  output logic             o_inside
);

  logic [POS_W:0] w_x_end;
  logic [POS_W:0] w_y_end;

  assign w_x_end  = {1'b0, i_box_x} + {1'b0, i_size};
  assign w_y_end  = {1'b0, i_box_y} + {1'b0, i_size};
  assign o_inside = (i_pt_x >= i_box_x) && ({1'b0, i_pt_x} < w_x_end) &&
                    (i_pt_y >= i_box_y) && ({1'b0, i_pt_y} < w_y_end);

endmodule

// File: rtl/shell_hit_judge.sv
// -----------------------------------------------------------------------------
// shell_hit_judge
// Scans one tank's shells round-robin, vanishes shells that leave the arena or
// strike the opposing tank, and keeps the opponent's hit/life count.
//   clk, rst     : clock, synchronous active-high reset
//   io (slave)   : game_state, shell positions, valid_shell, enemy position in;
//                  vanish, hit, hit_count, dead, dbg_state out
// Optional macro SHELL_WALL_MAP_EN: adds a wall-map ROM lookup; each shell
// then takes an address cycle (ST_SCAN) and a check cycle (ST_CHECK).
// -----------------------------------------------------------------------------
module shell_hit_judge
  import shell_pkg::*;
#(
  parameter int ARENA_X_MAX = 39,
  parameter int ARENA_Y_MAX = 29,
  parameter int TANK_W      = 2,
  parameter int LIVES       = 3
) (
  input logic              clk,
  input logic              rst,
  shell_hit_judge_if.slave io
);

  localparam logic [POS_W-1:0] X_MAX_C  = POS_W'(ARENA_X_MAX);
  localparam logic [POS_W-1:0] Y_MAX_C  = POS_W'(ARENA_Y_MAX);
  localparam logic [POS_W-1:0] SIZE_C   = POS_W'(TANK_W);
  localparam logic [1:0]       LIVES_C  = 2'(LIVES);
  localparam logic [1:0]       LIVES_M1 = 2'(LIVES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(N_SHELL - 1);

  scan_state_e        r_state;
  scan_state_e        w_next;
  logic [2:0]         r_idx;
  logic [N_SHELL-1:0] r_pending;
  logic [N_SHELL-1:0] r_vanish;
  logic               r_hit;
  logic [1:0]         r_hit_count;
  logic               r_dead;

  logic [POS_W-1:0]   w_x;
  logic [POS_W-1:0]   w_y;
  logic [N_SHELL-1:0] w_onehot;
  logic               w_enemy;
  logic               w_oob;
  logic               w_wall;
  logic               w_play;
  logic               w_eval;
  logic               w_fire;
  logic               w_fire_hit;
  logic               w_clear;

  // Position of the shell under the scan index.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < N_SHELL; k++) begin
      if (r_idx == 3'(k)) begin
        w_x = io.shell_x_pos[k*POS_W +: POS_W];
        w_y = io.shell_y_pos[k*POS_W +: POS_W];
      end
    end
  end

  assign w_onehot = {{(N_SHELL-1){1'b0}}, 1'b1} << r_idx;
  // Unsigned compare: a shell that stepped below 0 wraps to 63 and is caught.
  assign w_oob    = (w_x > X_MAX_C) || (w_y > Y_MAX_C);

  cell_in_box u_enemy_box (
    .i_pt_x  (w_x),
    .i_pt_y  (w_y),
    .i_box_x (io.enemy_x_pos),
    .i_box_y (io.enemy_y_pos),
    .i_size  (SIZE_C),
    .o_inside(w_enemy)
  );

`ifdef SHELL_WALL_MAP_EN
  assign io.wall_rd_addr = {w_y, w_x};
  assign w_wall          = io.wall_rd_data;
  assign w_eval          = (r_state == ST_CHECK);
`else
  assign w_wall          = 1'b0;
  assign w_eval          = (r_state == ST_SCAN);
`endif

  // Next state and per-cycle decisions.
  always_comb begin
    w_next     = r_state;
    w_play     = (io.game_state == GAME_PLAY);
    w_clear    = (io.game_state == GAME_RESTART) || (r_state == ST_RESTART);
    // A slot is judged only while its shell is in flight and not already
    // waiting for the shell block to take it back.
    w_fire     = w_eval && w_play && !io.valid_shell[r_idx] && !r_pending[r_idx] &&
                 (w_enemy || w_wall || w_oob);
    // Enemy contact wins over wall and bounds: it is the only case that scores.
    w_fire_hit = w_fire && w_enemy;

    if (io.game_state == GAME_RESTART) begin
      w_next = ST_RESTART;
    end else begin
      case (r_state)
        ST_WAIT:    if (w_play) w_next = ST_SCAN;
`ifdef SHELL_WALL_MAP_EN
        ST_SCAN:    w_next = w_play ? ST_CHECK : ST_WAIT;
`else
        ST_SCAN:    w_next = w_play ? ST_SCAN : ST_WAIT;
`endif
        ST_CHECK:   w_next = w_play ? ST_SCAN : ST_WAIT;
        ST_RESTART: w_next = ST_WAIT;
        default:    w_next = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_WAIT;
      r_idx       <= '0;
      r_pending   <= '0;
      r_vanish    <= '0;
      r_hit       <= 1'b0;
      r_hit_count <= '0;
      r_dead      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_idx       <= '0;
        r_pending   <= '0;
        r_vanish    <= '0;
        r_hit       <= 1'b0;
        r_hit_count <= '0;
        r_dead      <= 1'b0;
      end else begin
        r_vanish  <= w_fire ? w_onehot : '0;
        r_hit     <= w_fire_hit;
        r_pending <= (r_pending & ~io.valid_shell) | (w_fire ? w_onehot : '0);
        if (w_eval) begin
          r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
        if (w_fire_hit && (r_hit_count != LIVES_C)) begin
          r_hit_count <= r_hit_count + 2'd1;
          if (r_hit_count == LIVES_M1) r_dead <= 1'b1;
        end
      end
    end
  end

  assign io.vanish    = r_vanish;
  assign io.hit       = r_hit;
  assign io.hit_count = r_hit_count;
  assign io.dead      = r_dead;
  assign io.dbg_state = r_state;

endmodule

// File: tb/tb_shell_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_shell_hit_judge
// Directed bench for shell_hit_judge: bounds, underflow, near misses, enemy
// hits, serialized simultaneous hits with saturation, restart, and (when
// SHELL_WALL_MAP_EN is defined) a wall-map lookup.
// -----------------------------------------------------------------------------
module tb_shell_hit_judge;
  import shell_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shell_hit_judge_if io ();

  shell_hit_judge dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

`ifdef SHELL_WALL_MAP_EN
  // Map ROM model: a single wall cell at (x=7, y=5), one-cycle read latency.
  initial io.wall_rd_data = 1'b0;
  always @(posedge clk) io.wall_rd_data <= (io.wall_rd_addr == 12'h147);
  logic saw_addr = 1'b0;
  always @(negedge clk)
    if (io.dbg_state == ST_SCAN && io.wall_rd_addr == 12'h147) saw_addr = 1'b1;
`endif

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // At most one vanish bit per cycle, and a hit always comes with a vanish.
  always @(negedge clk) begin
    if (!rst && io.vanish != '0) check("vanish_onehot", 32'($onehot(io.vanish)), 32'd1);
    if (!rst && io.hit)          check("hit_has_vanish", 32'(io.vanish != '0), 32'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic set_shell(input int i, input logic [5:0] x, input logic [5:0] y);
    io.shell_x_pos[i*POS_W +: POS_W] = x;
    io.shell_y_pos[i*POS_W +: POS_W] = y;
  endtask

  task automatic release_all();
    io.valid_shell = 5'b11111;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, input int budget,
                            output logic [4:0] v, output logic h,
                            output logic [1:0] hc, output logic d);
    v = '0; h = 1'b0; hc = '0; d = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (io.vanish != '0) begin
        v = io.vanish; h = io.hit; hc = io.hit_count; d = io.dead;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s_timeout: got no vanish within %0d cycles, expected a pulse", tag, budget);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (io.vanish != '0) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] v;
  logic       h;
  logic [1:0] hc;
  logic       d;
  int         n;

  initial begin
    rst            = 1'b1;
    io.game_state  = 2'b00;
    io.valid_shell = 5'b11111;
    io.shell_x_pos = '0;
    io.shell_y_pos = '0;
    io.enemy_x_pos = 6'd20;
    io.enemy_y_pos = 6'd20;
    repeat (3) @(negedge clk);

    check("rst_vanish", 32'(io.vanish), 32'd0);
    check("rst_hit",    32'(io.hit), 32'd0);
    check("rst_count",  32'(io.hit_count), 32'd0);
    check("rst_dead",   32'(io.dead), 32'd0);
    check("rst_state",  32'(io.dbg_state), 32'(ST_WAIT));
    rst = 1'b0;

    // Bounds: x=40 is one column past the arena.
    io.game_state  = GAME_PLAY;
    set_shell(0, 6'd40, 6'd10);
    io.valid_shell = 5'b11110;
    wait_pulse("bounds", 30, v, h, hc, d);
    check("bounds_vanish", 32'(v), 32'h01);
    check("bounds_hit",    32'(h), 32'd0);
    check("bounds_count",  32'(hc), 32'd0);
    @(negedge clk);
    check("bounds_one_cycle", 32'(io.vanish), 32'd0);
    count_pulses(10, n);
    check("bounds_no_repeat", 32'(n), 32'd0);
    release_all();

    // Underflow: x wrapped to 63.
    set_shell(2, 6'd63, 6'd5);
    io.valid_shell = 5'b11011;
    wait_pulse("underflow", 30, v, h, hc, d);
    check("underflow_vanish", 32'(v), 32'h04);
    check("underflow_hit",    32'(h), 32'd0);
    count_pulses(6, n);
    check("underflow_no_repeat", 32'(n), 32'd0);
    release_all();

    // Near misses and the far arena corner: nothing vanishes.
    set_shell(0, 6'd22, 6'd20);
    set_shell(1, 6'd39, 6'd29);
    set_shell(2, 6'd19, 6'd21);
    set_shell(3, 6'd20, 6'd22);
    io.valid_shell = 5'b10000;
    count_pulses(20, n);
    check("near_miss_pulses", 32'(n), 32'd0);
    check("near_miss_count",  32'(io.hit_count), 32'd0);
    release_all();

    // Enemy hit on the far corner cell of the 2x2 tank.
    set_shell(3, 6'd21, 6'd21);
    io.valid_shell = 5'b10111;
    wait_pulse("enemy", 30, v, h, hc, d);
    check("enemy_vanish", 32'(v), 32'h08);
    check("enemy_hit",    32'(h), 32'd1);
    check("enemy_count",  32'(hc), 32'd1);
    check("enemy_dead",   32'(d), 32'd0);
    release_all();

    // Restart to a known index and count, then three shells on the tank at once.
    io.game_state = GAME_RESTART;
    @(negedge clk);
    check("restart1_count", 32'(io.hit_count), 32'd0);
    check("restart1_state", 32'(io.dbg_state), 32'(ST_RESTART));
    set_shell(0, 6'd20, 6'd20);
    set_shell(1, 6'd20, 6'd20);
    set_shell(4, 6'd20, 6'd20);
    io.valid_shell = 5'b01100;
    io.game_state  = GAME_PLAY;
    exp_q.push_back({24'd0, 1'b0, 2'd1, 5'b00001});
    exp_q.push_back({24'd0, 1'b0, 2'd2, 5'b00010});
    exp_q.push_back({24'd0, 1'b1, 2'd3, 5'b10000});
    for (int k = 0; k < 3; k++) begin
      wait_pulse("simul", 30, v, h, hc, d);
      check("simul_seq", {24'd0, d, hc, v}, exp_q.pop_front());
      check("simul_hit", 32'(h), 32'd1);
    end
    count_pulses(10, n);
    check("simul_no_repeat", 32'(n), 32'd0);
    release_all();

    // Fourth hit: still vanishes and pulses hit, count saturates.
    io.valid_shell = 5'b11110;
    wait_pulse("sat", 30, v, h, hc, d);
    check("sat_vanish", 32'(v), 32'h01);
    check("sat_hit",    32'(h), 32'd1);
    check("sat_count",  32'(hc), 32'd3);
    check("sat_dead",   32'(d), 32'd1);
    release_all();

    // Restart from dead, then resume from index 0.
    io.game_state = GAME_RESTART;
    @(negedge clk);
    check("restart2_count",  32'(io.hit_count), 32'd0);
    check("restart2_dead",   32'(io.dead), 32'd0);
    check("restart2_vanish", 32'(io.vanish), 32'd0);
    set_shell(0, 6'd50, 6'd0);
    set_shell(2, 6'd0, 6'd40);
    io.valid_shell = 5'b11010;
    io.game_state  = GAME_PLAY;
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h04);
    for (int k = 0; k < 2; k++) begin
      wait_pulse("resume", 30, v, h, hc, d);
      check("resume_order", 32'(v), exp_q.pop_front());
      check("resume_hit",   32'(h), 32'd0);
    end
    check("resume_count", 32'(io.hit_count), 32'd0);
    release_all();

`ifdef SHELL_WALL_MAP_EN
    // Wall cell at (7,5): vanish only, no hit.
    set_shell(1, 6'd7, 6'd5);
    io.valid_shell = 5'b11101;
    wait_pulse("wall", 30, v, h, hc, d);
    check("wall_vanish", 32'(v), 32'h02);
    check("wall_hit",    32'(h), 32'd0);
    check("wall_addr",   32'(saw_addr), 32'd1);
    release_all();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shell_hit_judge.md
Name: shell_hit_judge

Overview:
- Sits directly downstream of the shell block for one tank; instantiated once per tank.
- Checks that tank's 5 shells against the arena bounds and against the opposing tank.
- Drives the shell block's `vanish[4:0]` inputs.
- Reports hit pulses and a life count to the game FSM.

Parameters:
- ARENA_X_MAX, 39, largest legal shell x cell (40 columns).
- ARENA_Y_MAX, 29, largest legal shell y cell (30 rows).
- TANK_W, 2, enemy tank footprint in cells, square, anchored at top-left (x,y).
- LIVES, 3, hits needed to assert `dead`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_state  in  2  game phase; codes defined in package
- shell_x_pos  in  30  5×6-bit shell x; shell i at [6i+5:6i]
- shell_y_pos  in  30  5×6-bit shell y; same packing
- valid_shell  in  5  from shell block; 1 = idle/available, 0 = in flight
- enemy_x_pos  in  6  opposing tank x
- enemy_y_pos  in  6  opposing tank y
- vanish  out  5  one-cycle pulse per shell, to shell block
- hit  out  1  one-cycle pulse when a shell strikes the enemy
- hit_count  out  2  saturating hits on enemy, 0..LIVES
- dead  out  1  sticky; 1 when hit_count == LIVES

Behaviour:
- Reset: vanish=0, hit=0, hit_count=0, dead=0, scan index=0, pending[4:0]=0, FSM=WAIT.
- FSM states and transitions:
  - WAIT: nothing is evaluated. Goes to SCAN when game_state==PLAY.
  - SCAN: one shell per cycle, index round-robin 0,1,2,3,4,0… Goes to WAIT when game_state!=PLAY.
  - RESTART: entered from any state when game_state==RESTART. Clears hit_count, dead and pending; forces vanish=0 and index=0. Leaves to WAIT when game_state!=RESTART.
- Evaluation: shell i is evaluated only when valid_shell[i]==0 and pending[i]==0. Otherwise the slot is skipped; the index still advances.
- Out-of-bounds condition: x>ARENA_X_MAX or y>ARENA_Y_MAX.
  - Unsigned compare, so shell underflow from 0 to 63 counts as out of bounds.
- Enemy-hit condition: enemy_x ≤ x ≤ enemy_x+TANK_W-1 and the same for y.
  - Sum computed at 7 bits; no wrap.
- Either condition true → in the next cycle vanish[i]=1 for exactly one cycle, and pending[i] is set.
- Enemy hit additionally → hit=1 in that same cycle, and hit_count increments, saturating at LIVES.
- dead sets in the same cycle hit_count reaches LIVES. Further hits still vanish shells and pulse hit, but the count stays at LIVES.
- pending[i] clears when valid_shell[i]==1 is sampled. This prevents a double vanish during the one-cycle return of the shell block.
- Latency: worst case 5 cycles from a shell entering a hit cell to its vanish pulse; exactly 1 cycle after that shell's scan slot.
- Simultaneous hits: serialized by the scan, at most one vanish bit per cycle, so hit_count never skips a value.
- At most one vanish bit is high in any cycle.
- Reset or RESTART mid-pulse: vanish drops in the following cycle; no hit is counted.

Optional Feature:
- Macro SHELL_WALL_MAP_EN.
- When defined:
  - Added ports: wall_rd_addr out 12 ({y,x}) and wall_rd_data in 1, a synchronous map ROM with 1-cycle latency.
  - SCAN splits into ADDR (present address of shell i) and CHECK (sample wall_rd_data).
  - Throughput becomes one shell per 2 cycles; worst-case latency 10 cycles.
  - wall_rd_data==1 is treated as out of bounds: vanish only, no hit.
  - In the same CHECK cycle, priority is enemy hit > wall > bounds.
- When undefined: ports absent, single-phase scan.

Decomposition:
- Package shell_pkg holds:
  - GAME_PLAY=2'b01 and GAME_RESTART=2'b10.
  - N_SHELL=5 and POS_W=6.
  - Direction localparams UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - Scan-state enum.
- One combinational sub-module, cell_in_box: takes a point, a box origin and a size, and returns an overlap flag. It is reused for the enemy test and by the game block.

Test Plan:
- Bounds: game_state=PLAY, valid_shell=5'b11110, shell0=(40,10) → vanish=5'b00001 for one cycle within ≤5 cycles; hit=0; hit_count=0.
- Underflow: shell2=(63,5) in flight → vanish[2] pulses once; with valid_shell[2] held 0 for 3 more cycles, no second pulse.
- Enemy hit: enemy=(20,20), shell3=(21,21) in flight → vanish[3] and hit pulse in the same cycle; hit_count=1.
- Simultaneous: shells 0, 1 and 4 all at (20,20), LIVES=3 → three separate one-cycle vanish pulses in index order; hit_count steps 1,2,3; dead=1 after the third; a fourth hit leaves hit_count=3.
- Restart: with dead=1 and hit_count=3, drive game_state=GAME_RESTART for 1 cycle → next cycle hit_count=0, dead=0, vanish=0; returning to PLAY resumes scanning from index 0.
- SHELL_WALL_MAP_EN: wall_rd_data=1 at address {6'd5,6'd7}, shell1=(7,5) → wall_rd_addr=12'h147 in ADDR, vanish[1] one cycle after CHECK, hit=0.
